pc_sequencer: RTL
=================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have parameter INST_ADDR_WIDTH, default 6, width of every instruction address.
REQ-002 SHALL have parameter BOOT_ADDR, default 0, first fetch address loaded after start.
REQ-003 SHALL have port clk, input, 1, the clock; reset is reset, synchronous, active-high.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port start, input, 1, leaves IDLE or HALT.
REQ-006 SHALL have port stall, input, 1, holds the PC (hazard or memory wait).
REQ-007 SHALL have port redirect_valid, input, 1, taken branch or jump request.
REQ-008 SHALL have port redirect_target, input, INST_ADDR_WIDTH, branch or jump destination.
REQ-009 SHALL have port halt_req, input, 1, halt request.
REQ-010 SHALL have port pc_cur, input, INST_ADDR_WIDTH, current PC from the PC register.
REQ-011 SHALL have port bp_addr, input, INST_ADDR_WIDTH, breakpoint address.
REQ-012 SHALL have port bp_enable, input, 1, breakpoint armed.
REQ-013 SHALL have port pc_en, output, 1, PC register enable.
REQ-014 SHALL have port pc_wen, output, 1, PC register load strobe.
REQ-015 SHALL have port pc_next, output, INST_ADDR_WIDTH, PC load value.
REQ-016 SHALL have ports fetch_valid, flush, halted and bp_hit, output, 1 each, plus state_o, output, 3, encoded state.

Function
REQ-017 SHALL implement FSM states IDLE=0, BOOT=1, RUN=2, STALL=3, HALT=4.
REQ-018 SHALL drive all outputs combinationally from state, the pending register and the inputs, with zero latency to the PC register.
REQ-019 IDLE: pc_en=0 and fetch_valid=0; start -> BOOT.
REQ-020 BOOT: pc_en=1, pc_wen=1, pc_next=BOOT_ADDR for exactly one cycle; -> RUN.
REQ-021 RUN without other events: pc_en=1, pc_wen=0, fetch_valid=1.
REQ-022 RUN with redirect_valid: pc_en=1, pc_wen=1, pc_next=redirect_target, flush=1, fetch_valid=0, all in the same cycle.
REQ-023 Priority in RUN SHALL be halt_req > redirect_valid > stall > breakpoint > increment.
REQ-024 RUN with stall and no redirect: pc_en=0, fetch_valid=0; -> STALL.
REQ-025 STALL: pc_en=0; a redirect_valid SHALL latch into the pending register (valid bit + target), last write wins; stall low -> RUN.
REQ-026 First RUN cycle with pending valid: load the pending target (pc_wen=1, flush=1) and clear pending; a same-cycle redirect_valid overrides pending.
REQ-027 halt_req in RUN or STALL: pc_en=0, halted=1 from the next cycle; -> HALT. Pending is retained.
REQ-028 HALT: pc_en=0, halted=1; start -> RUN; the PC resumes unchanged, or at pending if pending is valid.
REQ-029 start outside IDLE and HALT SHALL be ignored; halt_req in IDLE or BOOT SHALL be ignored.
REQ-030 Address arithmetic is owned by the PC register; the sequencer SHALL perform no addition, and wrap from all-ones to 0 SHALL pass through unflagged.

Reset
REQ-031 While reset is high: state=IDLE, pending cleared, bp_hit=0, and all outputs 0 (pc_next=0, state_o=0).
REQ-032 Reset mid-operation (any state, pending set) SHALL abort within the same edge with no load pulse.

Configuration
REQ-033 With PC_BREAKPOINT_EN defined: in RUN with bp_enable=1, pc_cur==bp_addr and no higher-priority event -> pc_en=0 -> HALT; bp_hit is set and held sticky until start.
REQ-034 Without PC_BREAKPOINT_EN: bp_addr and bp_enable are ignored, bp_hit is tied to 0, and the ports remain present.

Structure
REQ-035 Shared package SHALL hold the state encoding constants and the default INST_ADDR_WIDTH.
REQ-036 SHALL be a single module; the optional sub-module is pc_bp_compare (breakpoint comparator), instantiated only under PC_BREAKPOINT_EN.

Verification
REQ-037 Reset, start, 5 free cycles -> BOOT loads 6'h00, then pc_en=1, wen=0 for 5 cycles, fetch_valid=1.
REQ-038 RUN with redirect_valid and redirect_target=6'h2A for 1 cycle -> same cycle pc_wen=1, pc_next=6'h2A, flush=1.
REQ-039 stall 3 cycles, redirect 6'h10 in cycle 2 -> pc_en=0 for 3 cycles, then one cycle pc_wen=1, pc_next=6'h10.
REQ-040 halt_req and redirect_valid asserted together -> HALT and halted=1; after start, pc loads the pending target.
REQ-041 PC_BREAKPOINT_EN, bp_addr=6'h07, boot 6'h04 -> halts with pc_cur=6'h07 and bp_hit=1; start clears bp_hit.
REQ-042 Reset asserted in STALL with pending set -> IDLE, all outputs 0, and no load after start until BOOT.

Source files
------------

// File: rtl/pc_sequencer_pkg.sv
// pc_sequencer_pkg: shared state encoding and default address width for the PC sequencer
package pc_sequencer_pkg;
  localparam int DEFAULT_INST_ADDR_WIDTH = 6;
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_BOOT  = 3'd1,
    S_RUN   = 3'd2,
    S_STALL = 3'd3,
    S_HALT  = 3'd4
  } state_e;
endpackage

// File: rtl/pc_sequencer_bp_compare.sv
// pc_bp_compare: breakpoint address comparator, only built when PC_BREAKPOINT_EN is defined
`ifdef PC_BREAKPOINT_EN
module pc_bp_compare
  import pc_sequencer_pkg::*;
#(
  parameter int INST_ADDR_WIDTH = DEFAULT_INST_ADDR_WIDTH
) (
  input  logic                       bp_enable,
  input  logic [INST_ADDR_WIDTH-1:0] pc_cur,
  input  logic [INST_ADDR_WIDTH-1:0] bp_addr,
  output logic                       match
);
  assign match = bp_enable && (pc_cur == bp_addr);
endmodule
`endif

// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch PC control FSM (boot, run, stall, redirect, halt); breakpoints with PC_BREAKPOINT_EN
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int                         INST_ADDR_WIDTH = DEFAULT_INST_ADDR_WIDTH,
  parameter logic [INST_ADDR_WIDTH-1:0] BOOT_ADDR       = '0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       stall,
  input  logic                       redirect_valid,
  input  logic [INST_ADDR_WIDTH-1:0] redirect_target,
  input  logic                       halt_req,
  input  logic [INST_ADDR_WIDTH-1:0] pc_cur,
  input  logic [INST_ADDR_WIDTH-1:0] bp_addr,
  input  logic                       bp_enable,
  output logic                       pc_en,
  output logic                       pc_wen,
  output logic [INST_ADDR_WIDTH-1:0] pc_next,
  output logic                       fetch_valid,
  output logic                       flush,
  output logic                       halted,
  output logic                       bp_hit,
  output logic [2:0]                 state_o
);
  state_e                     state_q, state_d;
  logic                       pend_v_q, pend_v_d;
  logic [INST_ADDR_WIDTH-1:0] pend_t_q, pend_t_d;
  logic                       bp_q, bp_d;
  logic                       bp_match;
  logic                       en_c, wen_c, fv_c, fl_c;
  logic [INST_ADDR_WIDTH-1:0] nx_c;

`ifdef PC_BREAKPOINT_EN
  pc_bp_compare #(.INST_ADDR_WIDTH(INST_ADDR_WIDTH)) u_bp (
    .bp_enable (bp_enable),
    .pc_cur    (pc_cur),
    .bp_addr   (bp_addr),
    .match     (bp_match)
  );
`else
  logic unused_bp;
  assign unused_bp = ^{bp_enable, bp_addr, pc_cur};
  assign bp_match  = 1'b0;
`endif

  // State, pending redirect and sticky breakpoint flag; reset wins on the same edge
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      pend_v_q <= 1'b0;
      pend_t_q <= '0;
      bp_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      pend_v_q <= pend_v_d;
      pend_t_q <= pend_t_d;
      bp_q     <= bp_d;
    end
  end

  // Next state and raw PC controls; RUN priority is halt > redirect > pending > stall > breakpoint > increment
  always_comb begin
    state_d  = state_q;
    pend_v_d = pend_v_q;
    pend_t_d = pend_t_q;
    bp_d     = bp_q;
    en_c     = 1'b0;
    wen_c    = 1'b0;
    fv_c     = 1'b0;
    fl_c     = 1'b0;
    nx_c     = '0;
    case (state_q)
      S_IDLE: state_d = start ? S_BOOT : S_IDLE;
      S_BOOT: begin
        en_c    = 1'b1;
        wen_c   = 1'b1;
        nx_c    = BOOT_ADDR;
        state_d = S_RUN;
      end
      S_RUN: begin
        if (halt_req) begin
          state_d  = S_HALT;
          pend_v_d = pend_v_q | redirect_valid;
          pend_t_d = redirect_valid ? redirect_target : pend_t_q;
        end else if (redirect_valid || pend_v_q) begin
          en_c     = 1'b1;
          wen_c    = 1'b1;
          fl_c     = 1'b1;
          nx_c     = redirect_valid ? redirect_target : pend_t_q;
          pend_v_d = 1'b0;
        end else if (stall) begin
          state_d = S_STALL;
        end else if (bp_match) begin
          state_d = S_HALT;
          bp_d    = 1'b1;
        end else begin
          en_c = 1'b1;
          fv_c = 1'b1;
        end
      end
      S_STALL: begin
        pend_v_d = pend_v_q | redirect_valid;
        pend_t_d = redirect_valid ? redirect_target : pend_t_q;
        state_d  = halt_req ? S_HALT : (stall ? S_STALL : S_RUN);
      end
      S_HALT: begin
        state_d = start ? S_RUN : S_HALT;
        bp_d    = start ? 1'b0 : bp_q;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are forced low while reset is high so an abort never emits a load pulse
  always_comb begin
    pc_en       = ~reset & en_c;
    pc_wen      = ~reset & wen_c;
    pc_next     = reset ? '0 : nx_c;
    fetch_valid = ~reset & fv_c;
    flush       = ~reset & fl_c;
    halted      = ~reset & (state_q == S_HALT);
    bp_hit      = ~reset & bp_q;
    state_o     = reset ? 3'd0 : state_q;
  end
endmodule
